// File: rtl/wb_pkg.sv
// Shared types for the Wishbone SRAM responder: request record, service states, miss data.
package wb_pkg;

    localparam int WB_ADDR_W = 16;
    localparam int WB_DATA_W = 8;

    // Returned on reads outside the RAM window, mimicking an undriven S100 bus.
    localparam logic [WB_DATA_W-1:0] MISS_DATA = '1;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic                 hit;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } srv_state_e;

endpackage

// File: rtl/wb_req_fifo.sv
// Request queue between the accept logic and the service FSM.
// An entry stays queued until its ack, so count equals outstanding requests.
module wb_req_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  wb_req_t          req_i,
    input  logic             pop_i,
    output wb_req_t          head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= req_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Pipelined Wishbone responder serving an on-chip byte RAM window with programmable wait states.
// Bus widths come from wb_pkg; WIDTH/ADDR_LINES must match them, and MEM_LINES < ADDR_LINES.
//   state | meaning
//   IDLE  | nothing queued
//   WAIT  | head request burning wait states
//   ACK   | head request is accessed and acked on the next edge
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int                    WIDTH       = 8,
    parameter int                    ADDR_LINES  = 16,
    parameter int                    MEM_LINES   = 12,
    parameter logic [ADDR_LINES-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter int                    QDEPTH      = 2,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [ADDR_LINES-1:0] i_wb_addr,
    input  logic [WIDTH-1:0]      i_wb_data,
    input  logic                  i_wp,
    output logic                  o_wb_ack,
    output logic                  o_wb_stall,
    output logic [WIDTH-1:0]      o_wb_data,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [WIDTH-1:0] mem [1 << MEM_LINES];

    srv_state_e       state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             ack_q;
    logic [WIDTH-1:0] rdata_q;

    wb_req_t          req_in;
    wb_req_t          head;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             do_access;
    logic             start;
    logic             unused_hi;

    assign accept    = i_wb_cyc & i_wb_stb & ~fifo_full;
    assign do_access = (state_q == ACK) & i_wb_cyc & ~i_rst;

    assign req_in.we   = i_wb_we;
    assign req_in.addr = i_wb_addr;
    assign req_in.data = i_wb_data;
    assign req_in.hit  = (i_wb_addr[ADDR_LINES-1:MEM_LINES] == BASE_ADDR[ADDR_LINES-1:MEM_LINES]);

    wb_req_fifo #(
        .DEPTH (QDEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .flush_i (~i_wb_cyc),
        .push_i  (accept),
        .req_i   (req_in),
        .pop_i   (do_access),
        .head_o  (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Window membership was resolved at accept time; the upper address bits are not needed later.
    assign unused_hi = ^head.addr[ADDR_LINES-1:MEM_LINES];

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE:    start = accept | ~fifo_empty;
            WAIT: begin
                if (wcnt_q == '0) state_d = ACK;
                else              wcnt_d  = wcnt_q - 1'b1;
            end
            ACK: begin
                if (accept || fifo_cnt > CNT_W'(1)) start   = 1'b1;
                else                                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            if (WAIT_STATES == 0) begin
                state_d = ACK;
            end else begin
                state_d = WAIT;
                wcnt_d  = 4'(WAIT_STATES - 1);
            end
        end
        if (!i_wb_cyc) state_d = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ack_q   <= do_access;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_access && head.we && head.hit && !i_wp)
            mem[head.addr[MEM_LINES-1:0]] <= head.data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            rdata_q <= '0;
        else if (do_access && !head.we)
            rdata_q <= head.hit ? mem[head.addr[MEM_LINES-1:0]] : MISS_DATA;
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = fifo_full;
    assign o_wb_data  = rdata_q;
    assign o_busy     = ~fifo_empty;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: three configurations, scoreboard checked on every ack.
module tb_wb_sram_slave;

    typedef struct {
        bit         is_rd;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic        wp    [3];
    logic [15:0] addr  [3];
    logic [7:0]  wdat  [3];
    logic        ack   [3];
    logic        stall [3];
    logic        busy  [3];
    logic [7:0]  rdat  [3];

    int   tests = 0;
    int   fails = 0;
    int   cyc_n = 0;
    int   ack_n      [3];
    int   ack_log    [3][32];
    bit   stall_seen [3];
    logic [7:0] last_rd [3];
    exp_t sbq0[$];
    exp_t sbq1[$];
    exp_t sbq2[$];

    wb_sram_slave #(.WAIT_STATES(0), .QDEPTH(2), .BASE_ADDR(16'h0000)) u0 (
        .i_clk(clk), .i_rst(rst[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
        .i_wb_addr(addr[0]), .i_wb_data(wdat[0]), .i_wp(wp[0]), .o_wb_ack(ack[0]),
        .o_wb_stall(stall[0]), .o_wb_data(rdat[0]), .o_busy(busy[0]));

    wb_sram_slave #(.WAIT_STATES(3), .QDEPTH(2), .BASE_ADDR(16'h0000)) u1 (
        .i_clk(clk), .i_rst(rst[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
        .i_wb_addr(addr[1]), .i_wb_data(wdat[1]), .i_wp(wp[1]), .o_wb_ack(ack[1]),
        .o_wb_stall(stall[1]), .o_wb_data(rdat[1]), .o_busy(busy[1]));

    wb_sram_slave #(.WAIT_STATES(2), .QDEPTH(2), .BASE_ADDR(16'h8000)) u2 (
        .i_clk(clk), .i_rst(rst[2]), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_we(we[2]),
        .i_wb_addr(addr[2]), .i_wb_data(wdat[2]), .i_wp(wp[2]), .o_wb_ack(ack[2]),
        .o_wb_stall(stall[2]), .o_wb_data(rdat[2]), .o_busy(busy[2]));

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int k, input exp_t e);
        case (k)
            0:       sbq0.push_back(e);
            1:       sbq1.push_back(e);
            default: sbq2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int k, output exp_t e, output bit got);
        got    = 1'b0;
        e.is_rd = 1'b0;
        e.data  = 8'h00;
        case (k)
            0:       if (sbq0.size() != 0) begin e = sbq0.pop_front(); got = 1'b1; end
            1:       if (sbq1.size() != 0) begin e = sbq1.pop_front(); got = 1'b1; end
            default: if (sbq2.size() != 0) begin e = sbq2.pop_front(); got = 1'b1; end
        endcase
    endtask

    function automatic int sb_size(input int k);
        case (k)
            0:       return sbq0.size();
            1:       return sbq1.size();
            default: return sbq2.size();
        endcase
    endfunction

    task automatic sb_clear(input int k);
        case (k)
            0:       sbq0.delete();
            1:       sbq1.delete();
            default: sbq2.delete();
        endcase
    endtask

    // Ack monitor: every ack must match the oldest expectation; writes leave read data untouched.
    always @(negedge clk) begin
        exp_t e;
        bit   got;
        for (int k = 0; k < 3; k++) begin
            if (stall[k] === 1'b1) stall_seen[k] = 1'b1;
            if (ack[k] === 1'b1) begin
                ack_log[k][ack_n[k] % 32] = cyc_n;
                ack_n[k]++;
                sb_pop(k, e, got);
                tests++;
                assert (got) else begin
                    fails++;
                    $error("FAIL unexpected_ack_u%0d: observed ack, expected no pending request", k);
                end
                if (got) chk($sformatf("ack_data_u%0d_rd%0d", k, e.is_rd), {24'h0, rdat[k]}, {24'h0, e.data});
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted the request.
    task automatic issue(input int k, input bit w, input logic [15:0] a, input logic [7:0] d,
                         output int acc);
        exp_t e;
        int   waited;
        cyc[k]  = 1'b1;
        stb[k]  = 1'b1;
        we[k]   = w;
        addr[k] = a;
        wdat[k] = w ? d : 8'h00;
        waited  = 0;
        while (stall[k] !== 1'b0 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        tests++;
        assert (waited < 50) else begin
            fails++;
            $error("FAIL accept_timeout_u%0d: observed stall for %0d cycles, expected acceptance", k, waited);
        end
        e.is_rd = !w;
        e.data  = w ? last_rd[k] : d;
        if (!w) last_rd[k] = d;
        sb_push(k, e);
        @(posedge clk); #1;
        acc = cyc_n;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        stb[k] = 1'b0;
        while ((sb_size(k) != 0 || busy[k] !== 1'b0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        assert (n < 100) else begin
            fails++;
            $error("FAIL drain_timeout_u%0d: observed %0d pending, expected 0", k, sb_size(k));
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, n0;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; wp[k] = 1'b0;
            addr[k] = 16'h0; wdat[k] = 8'h0; last_rd[k] = 8'h0; ack_n[k] = 0; stall_seen[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ack_u%0d", k),   {31'h0, ack[k]},   32'h0);
            chk($sformatf("rst_stall_u%0d", k), {31'h0, stall[k]}, 32'h0);
            chk($sformatf("rst_busy_u%0d", k),  {31'h0, busy[k]},  32'h0);
            chk($sformatf("rst_data_u%0d", k),  {24'h0, rdat[k]},  32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0;
            cyc[k] = 1'b1;
        end
        @(posedge clk); #1;

        // 1: zero wait states, write then back-to-back read of the same address
        n0 = ack_n[0];
        stall_seen[0] = 1'b0;
        issue(0, 1'b1, 16'h0123, 8'h5A, a0);
        issue(0, 1'b0, 16'h0123, 8'h5A, a1);
        drain(0);
        chk("t1_ack_count", ack_n[0] - n0, 2);
        chk("t1_latency", ack_log[0][n0 % 32] - a0, 1);
        chk("t1_back_to_back", ack_log[0][(n0 + 1) % 32] - ack_log[0][n0 % 32], 1);
        chk("t1_stall_seen", {31'h0, stall_seen[0]}, 0);

        // 4: protected write is acked but not stored
        issue(0, 1'b1, 16'h0040, 8'h33, a0);
        drain(0);
        wp[0] = 1'b1;
        issue(0, 1'b1, 16'h0040, 8'h11, a0);
        drain(0);
        wp[0] = 1'b0;
        issue(0, 1'b0, 16'h0040, 8'h33, a0);
        drain(0);

        // 2: three wait states, queue depth two, four continuous reads
        issue(1, 1'b1, 16'h0200, 8'hC0, a0);
        issue(1, 1'b1, 16'h0201, 8'hC1, a0);
        issue(1, 1'b1, 16'h0202, 8'hC2, a0);
        issue(1, 1'b1, 16'h0203, 8'hC3, a0);
        drain(1);
        n0 = ack_n[1];
        issue(1, 1'b0, 16'h0200, 8'hC0, a0);
        issue(1, 1'b0, 16'h0201, 8'hC1, a1);
        chk("t2_stall_after_two", {31'h0, stall[1]}, 1);
        issue(1, 1'b0, 16'h0202, 8'hC2, a2);
        issue(1, 1'b0, 16'h0203, 8'hC3, a3);
        drain(1);
        chk("t2_ack_count", ack_n[1] - n0, 4);
        chk("t2_first_latency", ack_log[1][n0 % 32] - a0, 4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("t2_spacing_%0d", i),
                ack_log[1][(n0 + i) % 32] - ack_log[1][(n0 + i - 1) % 32], 4);

        // 3: window at 0x8000; misses read all-ones and discard writes
        issue(2, 1'b1, 16'h8000, 8'hA5, a0);
        issue(2, 1'b0, 16'h0010, 8'hFF, a0);
        issue(2, 1'b1, 16'h9000, 8'h77, a0);
        issue(2, 1'b0, 16'h8000, 8'hA5, a0);
        issue(2, 1'b0, 16'h9000, 8'hFF, a0);
        drain(2);
        chk("t3_hold_miss_data", {24'h0, rdat[2]}, 32'hFF);

        // 5: cycle abort lands on the first write's ack edge; nothing queued is performed
        issue(2, 1'b1, 16'h8100, 8'h01, a0);
        issue(2, 1'b1, 16'h8101, 8'h02, a0);
        drain(2);
        n0 = ack_n[2];
        issue(2, 1'b1, 16'h8100, 8'hEE, a0);
        issue(2, 1'b1, 16'h8101, 8'hDD, a1);
        stb[2] = 1'b0;
        @(posedge clk); #1;
        cyc[2] = 1'b0;
        sb_clear(2);
        @(posedge clk); #1;
        chk("t5_ack_after_abort",   {31'h0, ack[2]},   0);
        chk("t5_busy_after_abort",  {31'h0, busy[2]},  0);
        chk("t5_stall_after_abort", {31'h0, stall[2]}, 0);
        cyc[2] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_no_acks", ack_n[2] - n0, 0);
        issue(2, 1'b0, 16'h8100, 8'h01, a0);
        issue(2, 1'b0, 16'h8101, 8'h02, a0);
        drain(2);

        // 6: reset lands on a pending read's ack edge, then on a pending write's ack edge
        issue(0, 1'b0, 16'h0040, 8'h33, a0);
        stb[0] = 1'b0;
        rst[0] = 1'b1;
        sb_clear(0);
        last_rd[0] = 8'h00;
        @(posedge clk); #1;
        chk("t6_ack_in_reset",  {31'h0, ack[0]},  0);
        chk("t6_busy_in_reset", {31'h0, busy[0]}, 0);
        chk("t6_data_in_reset", {24'h0, rdat[0]}, 0);
        rst[0] = 1'b0;
        @(posedge clk); #1;
        issue(0, 1'b1, 16'h0123, 8'h99, a0);
        stb[0] = 1'b0;
        rst[0] = 1'b1;
        sb_clear(0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(posedge clk); #1;
        chk("t6_ack_after_reset", {31'h0, ack[0]}, 0);
        issue(0, 1'b0, 16'h0123, 8'h5A, a0);
        issue(0, 1'b0, 16'h0040, 8'h33, a1);
        drain(0);
        chk("t6_final_data", {24'h0, rdat[0]}, 32'h33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
